// File: rtl/multi_operand_alu.sv
// Multi-operand ALU: an opcode plus NUM_OPERANDS operands on a shared bus, folded left-to-right.
// Define MULTI_OPERAND_ALU_SAT_EN to clamp ADD/SUB steps instead of wrapping.
module multi_operand_alu #(
  parameter  int DATA_WIDTH   = 8,
  parameter  int NUM_OPERANDS = 3,
  localparam int CNT_WIDTH    = $clog2(NUM_OPERANDS) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  opcode_valid,
  input  logic [2:0]            opcode,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  error
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_OPERANDS - 1);

  state_t                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  overflow_q, overflow_d;
  logic                  error_q, error_d;

  logic [DATA_WIDTH:0]   add_w;
  logic [DATA_WIDTH-1:0] step_acc;
  logic                  step_flag;

  // One fold step of the latched operation against the operand on the bus.
  always_comb begin
    add_w     = {1'b0, acc_q} + {1'b0, data};
    step_acc  = acc_q;
    step_flag = 1'b0;
    case (op_q)
      OP_ADD: begin
        step_acc  = add_w[DATA_WIDTH-1:0];
        step_flag = add_w[DATA_WIDTH];
`ifdef MULTI_OPERAND_ALU_SAT_EN
        if (step_flag) step_acc = '1;
`endif
      end
      OP_SUB: begin
        step_acc  = acc_q - data;
        step_flag = (data > acc_q);
`ifdef MULTI_OPERAND_ALU_SAT_EN
        if (step_flag) step_acc = '0;
`endif
      end
      OP_AND:  step_acc = acc_q & data;
      OP_OR:   step_acc = acc_q | data;
      OP_XOR:  step_acc = acc_q ^ data;
      default: step_acc = acc_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    overflow_d = overflow_q;
    error_d    = error_q;
    case (state_q)
      LOAD: begin
        acc_d = step_acc;
        ovf_d = ovf_q | step_flag;
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == LAST_CNT) begin
          state_d    = DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          result_d   = step_acc;
          overflow_d = ovf_q | step_flag;
          error_d    = 1'b0;
        end
      end
      default: begin
        // IDLE and DONE both accept a new op, which gives back-to-back issue.
        state_d = IDLE;
        busy_d  = 1'b0;
        if (opcode_valid) begin
          if (opcode <= OP_XOR) begin
            state_d = LOAD;
            busy_d  = 1'b1;
            op_d    = opcode;
            acc_d   = data;
            ovf_d   = 1'b0;
            cnt_d   = CNT_WIDTH'(1);
          end else begin
            state_d    = DONE;
            done_d     = 1'b1;
            result_d   = '0;
            overflow_d = 1'b0;
            error_d    = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_ADD;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      error_q    <= error_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;
  assign error    = error_q;

endmodule
